// File: rtl/ex_mem_if.sv
// Bundle of EX->MEM pipeline signals plus stall/flush control and madd/msub feedback.
// The slave modport is the pipeline register; the master modport is the EX/ctrl side.
interface ex_mem_if;
  logic [5:0]  stall;
  logic        flush;

  logic [4:0]  ex_waddr_reg_i;
  logic        ex_we_reg_i;
  logic [31:0] ex_wdata_i;
  logic        ex_whilo_i;
  logic [31:0] ex_hi_i;
  logic [31:0] ex_lo_i;
  logic [7:0]  ex_aluop_i;
  logic [31:0] ex_mem_addr_i;
  logic [31:0] ex_reg2_i;
  logic [63:0] ex_hilo_i;
  logic [1:0]  ex_cnt_i;

  logic [4:0]  mem_waddr_reg_o;
  logic        mem_we_reg_o;
  logic [31:0] mem_wdata_o;
  logic        mem_whilo_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;
  logic [7:0]  mem_aluop_o;
  logic [31:0] mem_mem_addr_o;
  logic [31:0] mem_reg2_o;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  modport master (
    output stall, flush,
    output ex_waddr_reg_i, ex_we_reg_i, ex_wdata_i, ex_whilo_i, ex_hi_i, ex_lo_i,
    output ex_aluop_i, ex_mem_addr_i, ex_reg2_i, ex_hilo_i, ex_cnt_i,
    input  mem_waddr_reg_o, mem_we_reg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o,
    input  mem_aluop_o, mem_mem_addr_o, mem_reg2_o, hilo_o, cnt_o
  );

  modport slave (
    input  stall, flush,
    input  ex_waddr_reg_i, ex_we_reg_i, ex_wdata_i, ex_whilo_i, ex_hi_i, ex_lo_i,
    input  ex_aluop_i, ex_mem_addr_i, ex_reg2_i, ex_hilo_i, ex_cnt_i,
    output mem_waddr_reg_o, mem_we_reg_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o,
    output mem_aluop_o, mem_mem_addr_o, mem_reg2_o, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: advances, holds or bubbles the EX payload under stall/flush,
// and keeps the madd/msub partial product and cycle count while EX is stalled.
module ex_mem (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  typedef struct packed {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
  } payload_t;

  // All-zero is the NOP: no GPR write, no HI/LO write, EXE_NOP_OP.
  localparam payload_t Bubble = '0;

  payload_t    ex_payload;
  payload_t    payload_d, payload_q;
  logic [63:0] hilo_d, hilo_q;
  logic [1:0]  cnt_d, cnt_q;

  always_comb begin
    ex_payload = '{
      waddr:    bus.ex_waddr_reg_i,
      we:       bus.ex_we_reg_i,
      wdata:    bus.ex_wdata_i,
      whilo:    bus.ex_whilo_i,
      hi:       bus.ex_hi_i,
      lo:       bus.ex_lo_i,
      aluop:    bus.ex_aluop_i,
      mem_addr: bus.ex_mem_addr_i,
      reg2:     bus.ex_reg2_i
    };

    payload_d = payload_q;
    if (bus.flush) begin
      payload_d = Bubble;
    end else if (bus.stall[3] && !bus.stall[4]) begin
      // EX stalled but MEM moves on: hand MEM a NOP rather than a duplicate.
      payload_d = Bubble;
    end else if (!bus.stall[3]) begin
      payload_d = ex_payload;
    end

    // Feedback survives only while EX is stalled mid-madd/msub.
    hilo_d = '0;
    cnt_d  = '0;
    if (!bus.flush && bus.stall[3]) begin
      hilo_d = bus.ex_hilo_i;
      cnt_d  = bus.ex_cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= Bubble;
      hilo_q    <= '0;
      cnt_q     <= '0;
    end else begin
      payload_q <= payload_d;
      hilo_q    <= hilo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.mem_waddr_reg_o = payload_q.waddr;
  assign bus.mem_we_reg_o    = payload_q.we;
  assign bus.mem_wdata_o     = payload_q.wdata;
  assign bus.mem_whilo_o     = payload_q.whilo;
  assign bus.mem_hi_o        = payload_q.hi;
  assign bus.mem_lo_o        = payload_q.lo;
  assign bus.mem_aluop_o     = payload_q.aluop;
  assign bus.mem_mem_addr_o  = payload_q.mem_addr;
  assign bus.mem_reg2_o      = payload_q.reg2;
  assign bus.hilo_o          = hilo_q;
  assign bus.cnt_o           = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed test-plan steps followed by random traffic,
// all checked against a reference model of the pipeline-register rules.
module tb_ex_mem;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ex_mem_if bus ();

  ex_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what MEM should be holding and what EX should get back.
  logic [4:0]  m_waddr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic        m_whilo;
  logic [31:0] m_hi, m_lo;
  logic [7:0]  m_aluop;
  logic [31:0] m_addr, m_reg2;
  logic [63:0] m_hilo;
  logic [1:0]  m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_waddr = 5'd0; m_we = 1'b0; m_wdata = 32'd0; m_whilo = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_aluop = 8'd0; m_addr = 32'd0; m_reg2 = 32'd0;
  endtask

  task automatic model_load();
    m_waddr = bus.ex_waddr_reg_i; m_we = bus.ex_we_reg_i; m_wdata = bus.ex_wdata_i;
    m_whilo = bus.ex_whilo_i; m_hi = bus.ex_hi_i; m_lo = bus.ex_lo_i;
    m_aluop = bus.ex_aluop_i; m_addr = bus.ex_mem_addr_i; m_reg2 = bus.ex_reg2_i;
  endtask

  // Apply one clock edge: predict from the inputs in force, then compare every output.
  task automatic tick();
    logic ex_stalled, mem_stalled, kill;
    logic [63:0] nxt_hilo;
    logic [1:0]  nxt_cnt;
    ex_stalled  = bus.stall[3];
    mem_stalled = bus.stall[4];
    kill        = rst || bus.flush;
    nxt_hilo    = (kill || !ex_stalled) ? 64'd0 : bus.ex_hilo_i;
    nxt_cnt     = (kill || !ex_stalled) ? 2'd0 : bus.ex_cnt_i;
    if (kill) model_bubble();
    else if (!ex_stalled) model_load();
    else if (!mem_stalled) model_bubble();
    // else: MEM stalled too, payload unchanged
    m_hilo = nxt_hilo;
    m_cnt  = nxt_cnt;
    @(posedge clk);
    #1;
    chk("waddr", 64'(bus.mem_waddr_reg_o), 64'(m_waddr));
    chk("we", 64'(bus.mem_we_reg_o), 64'(m_we));
    chk("wdata", 64'(bus.mem_wdata_o), 64'(m_wdata));
    chk("whilo", 64'(bus.mem_whilo_o), 64'(m_whilo));
    chk("hi", 64'(bus.mem_hi_o), 64'(m_hi));
    chk("lo", 64'(bus.mem_lo_o), 64'(m_lo));
    chk("aluop", 64'(bus.mem_aluop_o), 64'(m_aluop));
    chk("mem_addr", 64'(bus.mem_mem_addr_o), 64'(m_addr));
    chk("reg2", 64'(bus.mem_reg2_o), 64'(m_reg2));
    chk("hilo", bus.hilo_o, m_hilo);
    chk("cnt", 64'(bus.cnt_o), 64'(m_cnt));
  endtask

  task automatic rand_inputs();
    bus.ex_waddr_reg_i = 5'($urandom);
    bus.ex_we_reg_i    = 1'($urandom);
    bus.ex_wdata_i     = $urandom;
    bus.ex_whilo_i     = 1'($urandom);
    bus.ex_hi_i        = $urandom;
    bus.ex_lo_i        = $urandom;
    bus.ex_aluop_i     = 8'($urandom);
    bus.ex_mem_addr_i  = $urandom;
    bus.ex_reg2_i      = $urandom;
    bus.ex_hilo_i      = {$urandom, $urandom};
    bus.ex_cnt_i       = 2'($urandom);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_bubble();
    m_hilo = 64'd0;
    m_cnt  = 2'd0;

    // Reset with nonzero inputs and a stall pattern applied.
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 6'b001111;
    rand_inputs();
    bus.ex_cnt_i  = 2'd1;
    bus.ex_hilo_i = 64'hFFFF_0000_1234_5678;
    tick();
    tick();
    chk("rst_aluop", 64'(bus.mem_aluop_o), 64'h0);
    chk("rst_cnt", 64'(bus.cnt_o), 64'h0);
    rst = 1'b0;

    // Pass-through, back to back.
    bus.stall = 6'b000000;
    rand_inputs();
    bus.ex_wdata_i = 32'hDEADBEEF; bus.ex_waddr_reg_i = 5'd3; bus.ex_we_reg_i = 1'b1;
    tick();
    chk("pass_wdata0", 64'(bus.mem_wdata_o), 64'hDEADBEEF);
    chk("pass_waddr0", 64'(bus.mem_waddr_reg_o), 64'd3);
    chk("pass_we0", 64'(bus.mem_we_reg_o), 64'd1);
    bus.ex_wdata_i = 32'h12345678;
    tick();
    chk("pass_wdata1", 64'(bus.mem_wdata_o), 64'h12345678);

    // Bubble: EX stalled, MEM running.
    bus.stall = 6'b001111;
    rand_inputs();
    bus.ex_we_reg_i = 1'b1; bus.ex_whilo_i = 1'b1;
    bus.ex_wdata_i = 32'hCAFEF00D; bus.ex_hilo_i = 64'h0123_4567_89AB_CDEF; bus.ex_cnt_i = 2'd2;
    tick();
    chk("bub_we", 64'(bus.mem_we_reg_o), 64'd0);
    chk("bub_whilo", 64'(bus.mem_whilo_o), 64'd0);
    chk("bub_wdata", 64'(bus.mem_wdata_o), 64'd0);
    chk("bub_hilo", bus.hilo_o, 64'h0123_4567_89AB_CDEF);
    chk("bub_cnt", 64'(bus.cnt_o), 64'd2);

    // Hold: both EX and MEM stalled while inputs keep changing.
    bus.stall = 6'b000000;
    rand_inputs();
    bus.ex_wdata_i = 32'hA5A5A5A5;
    tick();
    bus.stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      chk("hold_wdata", 64'(bus.mem_wdata_o), 64'hA5A5A5A5);
    end
    bus.stall = 6'b000000;
    bus.ex_wdata_i = 32'h5A5A0001;
    tick();
    chk("release_wdata", 64'(bus.mem_wdata_o), 64'h5A5A0001);

    // madd: first cycle keeps the partial product, second cycle retires it.
    bus.stall = 6'b001111;
    bus.ex_cnt_i = 2'd1;
    bus.ex_hilo_i = 64'h0000_0001_0000_0002;
    tick();
    chk("madd_cnt1", 64'(bus.cnt_o), 64'd1);
    chk("madd_hilo1", bus.hilo_o, 64'h0000_0001_0000_0002);
    bus.stall = 6'b000000;
    bus.ex_whilo_i = 1'b1; bus.ex_hi_i = 32'd1; bus.ex_lo_i = 32'd5;
    tick();
    chk("madd_cnt2", 64'(bus.cnt_o), 64'd0);
    chk("madd_hilo2", bus.hilo_o, 64'd0);
    chk("madd_hi", 64'(bus.mem_hi_o), 64'd1);
    chk("madd_lo", 64'(bus.mem_lo_o), 64'd5);

    // Flush beats a held madd.
    bus.stall = 6'b011111;
    bus.ex_cnt_i = 2'd1;
    bus.ex_hilo_i = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    chk("pre_flush_cnt", 64'(bus.cnt_o), 64'd1);
    bus.flush = 1'b1;
    tick();
    chk("flush_cnt", 64'(bus.cnt_o), 64'd0);
    chk("flush_hilo", bus.hilo_o, 64'd0);
    chk("flush_wdata", 64'(bus.mem_wdata_o), 64'd0);
    bus.flush = 1'b0;

    // Reset mid-stall.
    bus.stall = 6'b000000;
    rand_inputs();
    tick();
    bus.stall = 6'b011111;
    rst = 1'b1;
    tick();
    chk("rst_stall_wdata", 64'(bus.mem_wdata_o), 64'd0);
    rst = 1'b0;

    // Random traffic over legal stall patterns.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      case ($urandom_range(0, 3))
        0: bus.stall = 6'b000000;
        1: bus.stall = 6'b001111;
        2: bus.stall = 6'b011111;
        default: bus.stall = 6'b111111;
      endcase
      bus.flush = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
